id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/forward_mux.sv | 24 ++
 rtl/id_ex_stage.sv | 187 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: ALU operation codes, ALUOp classes and R-type funct values.
// The ALU decodes the same ALU operation codes, so keep both sides in step when editing.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_SRL  = 3'b100,
        ALU_SLL  = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_ctrl_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ADDI  = 2'b11;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
    } ex_ctrl_t;

endpackage

// File: rtl/forward_mux.sv
// Operand bypass for one source register: the MEM-stage result has priority over WB,
// and register $0 is never forwarded.
module forward_mux
    import mips_pkg::*;
(
    input  logic [REG_W-1:0]  i_reg,
    input  logic [DATA_W-1:0] i_reg_data,
    input  logic              i_mem_regwrite,
    input  logic [REG_W-1:0]  i_mem_rd,
    input  logic [DATA_W-1:0] i_mem_result,
    input  logic              i_wb_regwrite,
    input  logic [REG_W-1:0]  i_wb_rd,
    input  logic [DATA_W-1:0] i_wb_result,
    output logic [DATA_W-1:0] o_data
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_mem_regwrite && (i_mem_rd == i_reg) && (i_reg != '0);
    assign w_wb_hit  = i_wb_regwrite  && (i_wb_rd  == i_reg) && (i_reg != '0);
    assign o_data    = w_mem_hit ? i_mem_result : (w_wb_hit ? i_wb_result : i_reg_data);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, ALU control decode and load-use
// hazard detection; drives the ALU operands combinationally from the registered state.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              ID_Valid,
    input  logic [DATA_W-1:0] ID_RsData,
    input  logic [DATA_W-1:0] ID_RtData,
    input  logic [REG_W-1:0]  ID_Rs,
    input  logic [REG_W-1:0]  ID_Rt,
    input  logic [REG_W-1:0]  ID_Rd,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic [4:0]        ID_Shamt,
    input  logic [5:0]        ID_Funct,
    input  logic [1:0]        ID_ALUOp,
    input  logic              ID_ALUSrc,
    input  logic              ID_RegDst,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_MemToReg,
    input  logic              MEM_RegWrite,
    input  logic [REG_W-1:0]  MEM_Rd,
    input  logic [DATA_W-1:0] MEM_Result,
    input  logic              WB_RegWrite,
    input  logic [REG_W-1:0]  WB_Rd,
    input  logic [DATA_W-1:0] WB_Result,
    output logic [DATA_W-1:0] In1,
    output logic [DATA_W-1:0] In2,
    output logic [2:0]        ALUcontrol,
    output logic              EX_Valid,
    output logic [REG_W-1:0]  EX_WriteReg,
    output logic [DATA_W-1:0] EX_StoreData,
    output logic              EX_RegWrite,
    output logic              EX_MemRead,
    output logic              EX_MemWrite,
    output logic              EX_MemToReg,
    output logic              EX_IllegalFunct,
    output logic              HazardStall
);

    logic              r_vld_p1;
    ex_ctrl_t          r_ctrl_p1;
    logic [DATA_W-1:0] r_rs_data_p1;
    logic [DATA_W-1:0] r_rt_data_p1;
    logic [DATA_W-1:0] r_imm_p1;
    logic [REG_W-1:0]  r_rs_p1;
    logic [REG_W-1:0]  r_rt_p1;
    logic [REG_W-1:0]  r_rd_p1;
    logic [4:0]        r_shamt_p1;
    logic [5:0]        r_funct_p1;
    logic [1:0]        r_aluop_p1;
    logic              r_alusrc_p1;
    logic              r_regdst_p1;

    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;
    logic [REG_W-1:0]  w_write_reg;
    logic              w_hazard;
    logic              w_is_shift;
    logic              w_funct_ok;
    alu_ctrl_e         w_alu_ctrl;

    // ---- ID -> EX register boundary ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p1     <= 1'b0;
            r_ctrl_p1    <= '0;
            r_rs_data_p1 <= '0;
            r_rt_data_p1 <= '0;
            r_imm_p1     <= '0;
            r_rs_p1      <= '0;
            r_rt_p1      <= '0;
            r_rd_p1      <= '0;
            r_shamt_p1   <= '0;
            r_funct_p1   <= '0;
            r_aluop_p1   <= '0;
            r_alusrc_p1  <= 1'b0;
            r_regdst_p1  <= 1'b0;
        end else if (Flush) begin
            r_vld_p1  <= 1'b0;
            r_ctrl_p1 <= '0;
        end else if (Stall) begin
            // Refresh operands so a producer that retires while we wait is captured.
            r_rs_data_p1 <= w_fwd_rs;
            r_rt_data_p1 <= w_fwd_rt;
        end else begin
            r_rs_data_p1 <= ID_RsData;
            r_rt_data_p1 <= ID_RtData;
            r_imm_p1     <= ID_Imm;
            r_rs_p1      <= ID_Rs;
            r_rt_p1      <= ID_Rt;
            r_rd_p1      <= ID_Rd;
            r_shamt_p1   <= ID_Shamt;
            r_funct_p1   <= ID_Funct;
            r_aluop_p1   <= ID_ALUOp;
            r_alusrc_p1  <= ID_ALUSrc;
            r_regdst_p1  <= ID_RegDst;
            if (w_hazard) begin
                r_vld_p1  <= 1'b0;
                r_ctrl_p1 <= '0;
            end else begin
                r_vld_p1  <= ID_Valid;
                r_ctrl_p1 <= '{ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg};
            end
        end
    end

    forward_mux u_fwd_rs (
        .i_reg          (r_rs_p1),
        .i_reg_data     (r_rs_data_p1),
        .i_mem_regwrite (MEM_RegWrite),
        .i_mem_rd       (MEM_Rd),
        .i_mem_result   (MEM_Result),
        .i_wb_regwrite  (WB_RegWrite),
        .i_wb_rd        (WB_Rd),
        .i_wb_result    (WB_Result),
        .o_data         (w_fwd_rs)
    );

    forward_mux u_fwd_rt (
        .i_reg          (r_rt_p1),
        .i_reg_data     (r_rt_data_p1),
        .i_mem_regwrite (MEM_RegWrite),
        .i_mem_rd       (MEM_Rd),
        .i_mem_result   (MEM_Result),
        .i_wb_regwrite  (WB_RegWrite),
        .i_wb_rd        (WB_Rd),
        .i_wb_result    (WB_Result),
        .o_data         (w_fwd_rt)
    );

    always_comb begin
        w_alu_ctrl = ALU_ADD;
        w_funct_ok = 1'b1;
        case (r_aluop_p1)
            ALUOP_ADD: w_alu_ctrl = ALU_ADD;
            ALUOP_SUB: w_alu_ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (r_funct_p1)
                    FUNCT_ADD:  w_alu_ctrl = ALU_ADD;
                    FUNCT_SUB:  w_alu_ctrl = ALU_SUB;
                    FUNCT_AND:  w_alu_ctrl = ALU_AND;
                    FUNCT_OR:   w_alu_ctrl = ALU_OR;
                    FUNCT_SLT:  w_alu_ctrl = ALU_SLT;
                    FUNCT_SLTU: w_alu_ctrl = ALU_SLTU;
                    FUNCT_SLL:  w_alu_ctrl = ALU_SLL;
                    FUNCT_SRL:  w_alu_ctrl = ALU_SRL;
                    default: begin
                        w_alu_ctrl = ALU_ADD;
                        w_funct_ok = 1'b0;
                    end
                endcase
            end
            default: w_alu_ctrl = ALU_ADD;
        endcase
    end

    // Shifts take the value to shift from rt and the amount from the shamt field.
    assign w_is_shift = (r_aluop_p1 == ALUOP_RTYPE) &&
                        ((r_funct_p1 == FUNCT_SLL) || (r_funct_p1 == FUNCT_SRL));

    assign In1        = w_is_shift ? w_fwd_rt : w_fwd_rs;
    assign In2        = w_is_shift  ? {{(DATA_W-5){1'b0}}, r_shamt_p1} :
                        r_alusrc_p1 ? r_imm_p1 : w_fwd_rt;
    assign ALUcontrol = w_alu_ctrl;

    assign w_write_reg  = r_regdst_p1 ? r_rd_p1 : r_rt_p1;
    assign EX_WriteReg  = w_write_reg;
    assign EX_StoreData = w_fwd_rt;

    assign EX_Valid        = r_vld_p1;
    assign EX_RegWrite     = r_vld_p1 & r_ctrl_p1.regwrite;
    assign EX_MemRead      = r_vld_p1 & r_ctrl_p1.memread;
    assign EX_MemWrite     = r_vld_p1 & r_ctrl_p1.memwrite;
    assign EX_MemToReg     = r_vld_p1 & r_ctrl_p1.memtoreg;
    assign EX_IllegalFunct = r_vld_p1 & (r_aluop_p1 == ALUOP_RTYPE) & ~w_funct_ok;

    assign w_hazard    = r_vld_p1 && r_ctrl_p1.memread && (w_write_reg != '0) &&
                         ((w_write_reg == ID_Rs) || (w_write_reg == ID_Rt));
    assign HazardStall = w_hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table, hand-written multi-cycle sequences and a
// randomized run compared against an instruction-level model of the stage.
module tb_id_ex_stage;

    typedef struct packed {
        logic        vld;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [1:0]  aluop;
        logic        alusrc;
        logic        regdst;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
    } instr_t;

    typedef struct {
        instr_t      id;
        logic        mem_rw;
        logic [4:0]  mem_rd;
        logic [31:0] mem_res;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic [31:0] wb_res;
        logic [31:0] e_in1;
        logic [31:0] e_in2;
        logic [2:0]  e_alu;
        logic        e_ill;
        logic [4:0]  e_wreg;
    } vec_t;

    logic clk, reset, stall, flush;
    instr_t id_in;
    logic mem_rw, wb_rw;
    logic [4:0] mem_rd, wb_rd;
    logic [31:0] mem_res, wb_res;

    logic [31:0] in1, in2, store_data;
    logic [2:0]  alu_ctl;
    logic [4:0]  wreg;
    logic ex_vld, ex_rw, ex_mr, ex_mw, ex_m2r, ex_ill, hz;

    instr_t m;
    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    id_ex_stage dut (
        .clk(clk), .reset(reset), .Stall(stall), .Flush(flush),
        .ID_Valid(id_in.vld), .ID_RsData(id_in.rsd), .ID_RtData(id_in.rtd),
        .ID_Rs(id_in.rs), .ID_Rt(id_in.rt), .ID_Rd(id_in.rd), .ID_Imm(id_in.imm),
        .ID_Shamt(id_in.shamt), .ID_Funct(id_in.funct), .ID_ALUOp(id_in.aluop),
        .ID_ALUSrc(id_in.alusrc), .ID_RegDst(id_in.regdst), .ID_RegWrite(id_in.rw),
        .ID_MemRead(id_in.mr), .ID_MemWrite(id_in.mw), .ID_MemToReg(id_in.m2r),
        .MEM_RegWrite(mem_rw), .MEM_Rd(mem_rd), .MEM_Result(mem_res),
        .WB_RegWrite(wb_rw), .WB_Rd(wb_rd), .WB_Result(wb_res),
        .In1(in1), .In2(in2), .ALUcontrol(alu_ctl), .EX_Valid(ex_vld),
        .EX_WriteReg(wreg), .EX_StoreData(store_data), .EX_RegWrite(ex_rw),
        .EX_MemRead(ex_mr), .EX_MemWrite(ex_mw), .EX_MemToReg(ex_m2r),
        .EX_IllegalFunct(ex_ill), .HazardStall(hz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input logic [4:0] rs, input logic [31:0] rsd,
                                  input logic [4:0] rt, input logic [31:0] rtd,
                                  input logic [4:0] rd, input logic [31:0] imm,
                                  input logic [4:0] shamt, input logic [5:0] funct,
                                  input logic [1:0] aluop, input logic alusrc,
                                  input logic regdst);
        instr_t i;
        i = '0;
        i.vld = 1'b1; i.rs = rs; i.rsd = rsd; i.rt = rt; i.rtd = rtd; i.rd = rd;
        i.imm = imm; i.shamt = shamt; i.funct = funct; i.aluop = aluop;
        i.alusrc = alusrc; i.regdst = regdst; i.rw = 1'b1;
        return i;
    endfunction

    task automatic add_vec(input instr_t i, input logic mrw, input logic [4:0] mrd,
                           input logic [31:0] mres, input logic wrw, input logic [4:0] wrd,
                           input logic [31:0] wres, input logic [31:0] e1, input logic [31:0] e2,
                           input logic [2:0] ea, input logic ei, input logic [4:0] ew);
        vec_t v;
        v.id = i; v.mem_rw = mrw; v.mem_rd = mrd; v.mem_res = mres;
        v.wb_rw = wrw; v.wb_rd = wrd; v.wb_res = wres;
        v.e_in1 = e1; v.e_in2 = e2; v.e_alu = ea; v.e_ill = ei; v.e_wreg = ew;
        vecs.push_back(v);
    endtask

    // ---- reference model: what the instruction held in EX should present ----
    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
        if (r != 0 && mem_rw && mem_rd == r) return mem_res;
        if (r != 0 && wb_rw && wb_rd == r) return wb_res;
        return d;
    endfunction

    function automatic bit is_shift(input instr_t i);
        return i.aluop == 2'd2 && (i.funct == 6'h00 || i.funct == 6'h02);
    endfunction

    function automatic logic [2:0] exp_alu(input instr_t i);
        if (i.aluop == 2'd1) return 3'b110;
        if (i.aluop != 2'd2) return 3'b010;
        case (i.funct)
            6'h22: return 3'b110;
            6'h24: return 3'b000;
            6'h25: return 3'b001;
            6'h2A: return 3'b111;
            6'h2B: return 3'b011;
            6'h00: return 3'b101;
            6'h02: return 3'b100;
            default: return 3'b010;
        endcase
    endfunction

    function automatic bit exp_ill(input instr_t i);
        return i.vld && i.aluop == 2'd2 &&
               !(i.funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h00, 6'h02});
    endfunction

    function automatic logic [4:0] dest(input instr_t i);
        return i.regdst ? i.rd : i.rt;
    endfunction

    function automatic bit exp_hazard(input instr_t i);
        return i.vld && i.mr && dest(i) != 0 && (dest(i) == id_in.rs || dest(i) == id_in.rt);
    endfunction

    // Compare DUT against the model, then advance the model by one clock.
    task automatic tick();
        instr_t nxt;
        logic [31:0] e1, e2;
        #1;
        check("EX_Valid", ex_vld, m.vld);
        check("EX_RegWrite", ex_rw, m.vld & m.rw);
        check("EX_MemRead", ex_mr, m.vld & m.mr);
        check("EX_MemWrite", ex_mw, m.vld & m.mw);
        check("EX_MemToReg", ex_m2r, m.vld & m.m2r);
        check("EX_IllegalFunct", ex_ill, exp_ill(m));
        check("HazardStall", hz, exp_hazard(m));
        if (m.vld) begin
            e1 = is_shift(m) ? fwd(m.rt, m.rtd) : fwd(m.rs, m.rsd);
            e2 = is_shift(m) ? {27'd0, m.shamt} : (m.alusrc ? m.imm : fwd(m.rt, m.rtd));
            check("In1", in1, e1);
            check("In2", in2, e2);
            check("ALUcontrol", alu_ctl, exp_alu(m));
            check("EX_WriteReg", wreg, dest(m));
            check("EX_StoreData", store_data, fwd(m.rt, m.rtd));
        end
        nxt = m;
        if (flush) begin
            nxt.vld = 0; nxt.rw = 0; nxt.mr = 0; nxt.mw = 0; nxt.m2r = 0;
        end else if (stall) begin
            nxt.rsd = fwd(m.rs, m.rsd);
            nxt.rtd = fwd(m.rt, m.rtd);
        end else begin
            nxt = id_in;
            if (exp_hazard(m)) begin
                nxt.vld = 0; nxt.rw = 0; nxt.mr = 0; nxt.mw = 0; nxt.m2r = 0;
            end
        end
        @(posedge clk);
        m = nxt;
        @(negedge clk);
    endtask

    task automatic no_fwd();
        mem_rw = 0; mem_rd = 0; mem_res = 0; wb_rw = 0; wb_rd = 0; wb_res = 0;
    endtask

    initial begin
        logic [5:0] fl[9];
        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h3F};
        reset = 1; stall = 0; flush = 0; id_in = '0; no_fwd(); m = '0;

        add_vec(mk(1, 5, 2, 7, 3, 0, 0, 6'h20, 2, 0, 1), 0,0,0, 0,0,0, 5, 7, 3'b010, 0, 3);
        add_vec(mk(1, 9, 2, 4, 3, 0, 0, 6'h22, 2, 0, 1), 0,0,0, 0,0,0, 9, 4, 3'b110, 0, 3);
        add_vec(mk(1, 'hF0, 2, 'h3C, 3, 0, 0, 6'h24, 2, 0, 1), 0,0,0, 0,0,0, 'hF0, 'h3C, 3'b000, 0, 3);
        add_vec(mk(1, 'hF0, 2, 'h3C, 3, 0, 0, 6'h25, 2, 0, 1), 0,0,0, 0,0,0, 'hF0, 'h3C, 3'b001, 0, 3);
        add_vec(mk(1, 1, 2, 2, 3, 0, 0, 6'h2A, 2, 0, 1), 0,0,0, 0,0,0, 1, 2, 3'b111, 0, 3);
        add_vec(mk(1, 1, 2, 2, 3, 0, 0, 6'h2B, 2, 0, 1), 0,0,0, 0,0,0, 1, 2, 3'b011, 0, 3);
        add_vec(mk(1, 'hDEAD, 2, 'h10, 3, 0, 4, 6'h00, 2, 0, 1), 0,0,0, 0,0,0, 'h10, 4, 3'b101, 0, 3);
        add_vec(mk(1, 'hDEAD, 2, 'h80000000, 3, 0, 31, 6'h02, 2, 0, 1), 0,0,0, 0,0,0,
                'h80000000, 31, 3'b100, 0, 3);
        add_vec(mk(1, 100, 2, 7, 3, 'hFFFFFFF0, 0, 6'h3F, 0, 1, 0), 0,0,0, 0,0,0,
                100, 'hFFFFFFF0, 3'b010, 0, 2);
        add_vec(mk(1, 100, 2, 7, 3, 0, 0, 6'h3F, 1, 0, 0), 0,0,0, 0,0,0, 100, 7, 3'b110, 0, 2);
        add_vec(mk(6, 1, 7, 2, 8, 'h123, 0, 6'h22, 3, 1, 0), 0,0,0, 0,0,0, 1, 'h123, 3'b010, 0, 7);
        add_vec(mk(1, 5, 2, 7, 3, 0, 0, 6'h3F, 2, 0, 1), 0,0,0, 0,0,0, 5, 7, 3'b010, 1, 3);
        add_vec(mk(3, 'h99, 2, 7, 4, 0, 0, 6'h20, 2, 0, 1), 1,3,'h11, 1,3,'h22, 'h11, 7, 3'b010, 0, 4);
        add_vec(mk(3, 'h99, 2, 7, 4, 0, 0, 6'h20, 2, 0, 1), 0,3,'h11, 1,3,'h22, 'h22, 7, 3'b010, 0, 4);
        add_vec(mk(0, 'h55, 2, 7, 4, 0, 0, 6'h20, 2, 0, 1), 1,0,'h11, 1,0,'h22, 'h55, 7, 3'b010, 0, 4);
        add_vec(mk(1, 5, 2, 7, 4, 0, 0, 6'h20, 2, 0, 1), 1,2,'h77, 0,0,0, 5, 'h77, 3'b010, 0, 4);

        @(negedge clk);
        check("reset EX_Valid", ex_vld, 0);
        check("reset In1", in1, 0);
        check("reset In2", in2, 0);
        check("reset ALUcontrol", alu_ctl, 3'b010);
        check("reset EX_WriteReg", wreg, 0);
        check("reset HazardStall", hz, 0);
        check("reset EX_IllegalFunct", ex_ill, 0);
        reset = 0;

        foreach (vecs[k]) begin
            id_in = vecs[k].id;
            mem_rw = vecs[k].mem_rw; mem_rd = vecs[k].mem_rd; mem_res = vecs[k].mem_res;
            wb_rw = vecs[k].wb_rw; wb_rd = vecs[k].wb_rd; wb_res = vecs[k].wb_res;
            tick();
            #1;
            check($sformatf("vec%0d In1", k), in1, vecs[k].e_in1);
            check($sformatf("vec%0d In2", k), in2, vecs[k].e_in2);
            check($sformatf("vec%0d ALUcontrol", k), alu_ctl, vecs[k].e_alu);
            check($sformatf("vec%0d IllegalFunct", k), ex_ill, vecs[k].e_ill);
            check($sformatf("vec%0d WriteReg", k), wreg, vecs[k].e_wreg);
            check($sformatf("vec%0d EX_Valid", k), ex_vld, 1);
        end
        no_fwd();

        // load-use: lw $4 in EX, consumer reads $4 as rt
        id_in = mk(1, 0, 4, 0, 0, 8, 0, 6'h00, 0, 1, 0);
        id_in.mr = 1; id_in.m2r = 1;
        tick();
        id_in = mk(1, 3, 4, 9, 5, 0, 0, 6'h20, 2, 0, 1);
        #1;
        check("loaduse HazardStall", hz, 1);
        tick();
        #1;
        check("loaduse bubble EX_Valid", ex_vld, 0);
        check("loaduse bubble RegWrite", ex_rw, 0);
        check("loaduse bubble MemRead", ex_mr, 0);
        check("loaduse bubble MemToReg", ex_m2r, 0);
        check("loaduse bubble HazardStall", hz, 0);
        tick();

        // three-cycle stall, WB producer of rs retires in the first stall cycle
        id_in = mk(5, 1, 6, 2, 7, 0, 0, 6'h20, 2, 0, 1);
        tick();
        stall = 1; id_in.vld = 0;
        wb_rw = 1; wb_rd = 5; wb_res = 'hABCD;
        tick();
        no_fwd();
        tick();
        tick();
        stall = 0;
        #1;
        check("stall refresh In1", in1, 'hABCD);
        check("stall refresh EX_Valid", ex_vld, 1);
        tick();

        // Flush and Stall together squash to a bubble
        id_in = mk(1, 5, 2, 7, 3, 0, 0, 6'h20, 2, 0, 1);
        tick();
        stall = 1; flush = 1;
        tick();
        #1;
        check("flush+stall EX_Valid", ex_vld, 0);
        check("flush+stall RegWrite", ex_rw, 0);
        stall = 0; flush = 0;
        tick();

        // asynchronous reset in the middle of a stall
        id_in = mk(3, 'h1234, 4, 'h5678, 9, 0, 0, 6'h22, 2, 0, 1);
        id_in.mw = 1;
        tick();
        stall = 1;
        #2 reset = 1;
        #1;
        check("async reset EX_Valid", ex_vld, 0);
        check("async reset In1", in1, 0);
        check("async reset In2", in2, 0);
        check("async reset ALUcontrol", alu_ctl, 3'b010);
        check("async reset MemWrite", ex_mw, 0);
        check("async reset HazardStall", hz, 0);
        reset = 0; m = '0; stall = 0;
        id_in = mk(1, 'h42, 2, 'h43, 3, 0, 0, 6'h24, 2, 0, 1);
        tick();
        #1;
        check("post-reset load EX_Valid", ex_vld, 1);
        check("post-reset load In1", in1, 'h42);
        check("post-reset load ALUcontrol", alu_ctl, 3'b000);

        for (int c = 0; c < 400; c++) begin
            id_in.vld    = ($urandom_range(0, 7) != 0);
            id_in.rsd    = $urandom;
            id_in.rtd    = $urandom;
            id_in.imm    = $urandom;
            id_in.rs     = 5'($urandom_range(0, 3));
            id_in.rt     = 5'($urandom_range(0, 3));
            id_in.rd     = 5'($urandom_range(0, 3));
            id_in.shamt  = 5'($urandom);
            id_in.funct  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fl[$urandom_range(0, 8)];
            id_in.aluop  = 2'($urandom);
            id_in.alusrc = 1'($urandom);
            id_in.regdst = 1'($urandom);
            id_in.rw     = 1'($urandom);
            id_in.mr     = ($urandom_range(0, 2) == 0);
            id_in.mw     = 1'($urandom);
            id_in.m2r    = 1'($urandom);
            stall  = ($urandom_range(0, 7) == 0);
            flush  = ($urandom_range(0, 15) == 0);
            mem_rw = 1'($urandom); mem_rd = 5'($urandom_range(0, 3)); mem_res = $urandom;
            wb_rw  = 1'($urandom); wb_rd  = 5'($urandom_range(0, 3)); wb_res  = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
